onchip_ram_arbiter: RTL

ONCHIP_RAM_ARBITER -- requirements
Module: onchip_ram_arbiter

---
 rtl/onchip_ram_arbiter_pkg.sv | 18 +
 rtl/onchip_ram_arbiter_rr_arb2.sv | 46 ++++
 rtl/onchip_ram_arbiter.sv | 90 +++++++++
 3 files changed

// File: rtl/onchip_ram_arbiter_pkg.sv
// Shared definitions for the on-chip RAM arbiter.
//   ADDR_W_DEFAULT / DATA_W_DEFAULT : default RAM word-address and data widths
//   MID_IMEM / MID_DMEM             : master ids (instruction master 0, data master 1)
//   rd_tag_t                        : outstanding-read tag (valid + master id)
package onchip_ram_arbiter_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 13;
  localparam int unsigned DATA_W_DEFAULT = 64;

  localparam logic MID_IMEM = 1'b0;
  localparam logic MID_DMEM = 1'b1;

  typedef struct packed {
    logic valid;
    logic mid;
  } rd_tag_t;

endpackage

// File: rtl/onchip_ram_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter with its priority register.
//   clk, reset : clock and synchronous active-high reset
//   req0, req1 : requests from master 0 (imem) and master 1 (dmem)
//   gnt0, gnt1 : combinational one-hot-or-zero grants
// After reset the data master (1) holds priority. Each grant hands priority
// to the other master; idle cycles leave it unchanged.
module onchip_ram_arbiter_rr_arb2
  import onchip_ram_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic prio_q, prio_d;

  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    prio_d = prio_q;
    if (req0 && req1) begin
      gnt1 = (prio_q == MID_DMEM);
      gnt0 = ~gnt1;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
    if (gnt0) begin
      prio_d = MID_DMEM;
    end else if (gnt1) begin
      prio_d = MID_IMEM;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= MID_DMEM;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/onchip_ram_arbiter.sv
// Arbitrates an instruction master (m0, read-only) and a data master (m1)
// onto a single-port on-chip RAM with registered address / unregistered data.
//   clk, reset          : clock, synchronous active-high reset
//   m0_*                : instruction master (address, read, waitrequest, readdata[valid])
//   m1_*                : data master (address, read, write, byteenable, writedata, ...)
//   ram_*               : RAM port (address, byteenable, writedata, chipselect, write,
//                         clken, readdata)
// Read data returns exactly one cycle after the grant; a tag register remembers
// which master owns that return slot. A grant can be issued every cycle.
module onchip_ram_arbiter
  import onchip_ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  // Instruction master
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  output logic                m0_waitrequest,
  output logic                m0_readdatavalid,
  output logic [DATA_W-1:0]   m0_readdata,
  // Data master
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic                m1_readdatavalid,
  output logic [DATA_W-1:0]   m1_readdata,
  // RAM
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata
);

  logic    m0_req, m1_req;
  logic    gnt0, gnt1;
  rd_tag_t tag_q, tag_d;

  // Requests are masked during reset so nothing is granted or tagged then.
  assign m0_req = m0_read & ~reset;
  assign m1_req = (m1_read | m1_write) & ~reset;

  onchip_ram_arbiter_rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req0  (m0_req),
    .req1  (m1_req),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  always_comb begin
    ram_chipselect = gnt0 | gnt1;
    // Read+write together from m1 is a write only.
    ram_write      = gnt1 & m1_write;
    ram_address    = gnt1 ? m1_address : m0_address;
    ram_byteenable = gnt1 ? m1_byteenable : '1;
    ram_writedata  = m1_writedata;

    m0_waitrequest = reset | (m0_req & ~gnt0);
    m1_waitrequest = reset | (m1_req & ~gnt1);

    tag_d.valid = gnt0 | (gnt1 & ~m1_write);
    tag_d.mid   = gnt1 ? MID_DMEM : MID_IMEM;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  // Gating with reset drops a return slot that reset cuts across.
  assign m0_readdatavalid = tag_q.valid & ~reset & (tag_q.mid == MID_IMEM);
  assign m1_readdatavalid = tag_q.valid & ~reset & (tag_q.mid == MID_DMEM);
  assign m0_readdata      = ram_readdata;
  assign m1_readdata      = ram_readdata;
  assign ram_clken        = ~reset;

endmodule
